// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// The master issues a held request; the slave completes it with ack plus read data.
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input  ack, rdata);
  modport slave  (input  req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on a variable-latency req/ack port,
// stalls EX/MEM while an access is in flight, and registers the MEM/WB payload.
module mem_access_stage #(
  parameter int DATA_BITS = 32,
  parameter int PC_BITS   = 32,
  parameter int IR_BITS   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_BITS-1:0]   PC_in,
  input  logic [IR_BITS-1:0]   IR_in,
  input  logic [DATA_BITS-1:0] result_1,
  input  logic [DATA_BITS-1:0] regfile_out2,
  input  logic [5:0]           write,
  input  logic                 MemToReg,
  input  logic                 MemWrite,
  input  logic                 RegWrite,
  input  logic                 Jal,
  input  logic                 Sh,
  input  logic                 Sb,
  input  logic                 ExtrSigned,
  input  logic                 Syscall,
  input  logic                 CP0ToReg,
  input  logic [1:0]           ExtrWord,
  input  logic [DATA_BITS-1:0] CP0_out,
  mem_access_stage_if.master   dmem,
  output logic                 mem_stall,
  output logic [PC_BITS-1:0]   wb_PC,
  output logic [IR_BITS-1:0]   wb_IR,
  output logic                 wb_RegWrite,
  output logic [5:0]           wb_write,
  output logic [DATA_BITS-1:0] wb_data,
  output logic                 wb_Syscall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic           req_q, we_q;
  logic [31:0]    addr_q, wdata_q, rdata_q;
  logic [3:0]     be_q;

  logic           mem_op;
  logic [1:0]     off;
  logic [31:0]    addr_c, wdata_c;
  logic [3:0]     be_c;
  logic [15:0]    half;
  logic [7:0]     byte_v;
  logic [31:0]    load_val, wb_data_c;

  assign mem_op = MemToReg | MemWrite;
  assign off    = result_1[1:0];
  assign addr_c = {result_1[31:2], 2'b00};

  // Sb wins over Sh; narrow data is replicated so every enabled lane carries it.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = regfile_out2;
    if (MemWrite && Sb) begin
      be_c    = 4'b0001 << off;
      wdata_c = {4{regfile_out2[7:0]}};
    end else if (MemWrite && Sh) begin
      be_c    = off[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{regfile_out2[15:0]}};
    end
  end

  // Bus fields come from the registered request while the access is outstanding.
  assign dmem.req   = req_q & ~rst;
  assign dmem.we    = (state == BUSY) ? we_q    : MemWrite;
  assign dmem.addr  = (state == BUSY) ? addr_q  : addr_c;
  assign dmem.be    = (state == BUSY) ? be_q    : (MemWrite ? be_c : 4'b1111);
  assign dmem.wdata = (state == BUSY) ? wdata_q : wdata_c;

  assign mem_stall = (state == BUSY) || (state == IDLE && mem_op);

  always_comb begin
    half   = off[1] ? rdata_q[31:16] : rdata_q[15:0];
    byte_v = 8'h00;
    case (off)
      2'd0: byte_v = rdata_q[7:0];
      2'd1: byte_v = rdata_q[15:8];
      2'd2: byte_v = rdata_q[23:16];
      2'd3: byte_v = rdata_q[31:24];
      default: byte_v = 8'h00;
    endcase
    case (ExtrWord)
      2'b01:   load_val = ExtrSigned ? {{16{half[15]}}, half}    : {16'h0000, half};
      2'b10:   load_val = ExtrSigned ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
      default: load_val = rdata_q;
    endcase
  end

  always_comb begin
    wb_data_c = result_1;
    if (CP0ToReg)      wb_data_c = CP0_out;
    else if (Jal)      wb_data_c = DATA_BITS'(PC_in) + 32'd4;
    else if (MemToReg) wb_data_c = load_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wb_PC       <= '0;
      wb_IR       <= '0;
      wb_RegWrite <= 1'b0;
      wb_write    <= '0;
      wb_data     <= '0;
      wb_Syscall  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mem_op) begin
          state   <= BUSY;
          req_q   <= 1'b1;
          we_q    <= MemWrite;
          addr_q  <= addr_c;
          be_q    <= MemWrite ? be_c : 4'b1111;
          wdata_q <= wdata_c;
        end
        BUSY: if (dmem.ack) begin
          state   <= DONE;
          req_q   <= 1'b0;
          rdata_q <= dmem.rdata;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // A stalled cycle feeds a bubble to WB.
      if (mem_stall) begin
        wb_PC       <= '0;
        wb_IR       <= '0;
        wb_RegWrite <= 1'b0;
        wb_write    <= '0;
        wb_data     <= '0;
        wb_Syscall  <= 1'b0;
      end else begin
        wb_PC       <= PC_in;
        wb_IR       <= IR_in;
        wb_RegWrite <= RegWrite;
        wb_write    <= write;
        wb_data     <= wb_data_c;
        wb_Syscall  <= Syscall;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads, stores, Jal/CP0
// priority, ack outside BUSY, and reset in the middle of an access.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_in, IR_in, result_1, regfile_out2, CP0_out;
  logic [5:0]  write;
  logic        MemToReg, MemWrite, RegWrite, Jal, Sh, Sb, ExtrSigned, Syscall, CP0ToReg;
  logic [1:0]  ExtrWord;
  logic        mem_stall;
  logic [31:0] wb_PC, wb_IR, wb_data;
  logic        wb_RegWrite, wb_Syscall;
  logic [5:0]  wb_write;
  int          total = 0;
  int          bad   = 0;

  mem_access_stage_if dmem();

  mem_access_stage dut (
    .clk(clk), .rst(rst), .PC_in(PC_in), .IR_in(IR_in), .result_1(result_1),
    .regfile_out2(regfile_out2), .write(write), .MemToReg(MemToReg), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .Jal(Jal), .Sh(Sh), .Sb(Sb), .ExtrSigned(ExtrSigned),
    .Syscall(Syscall), .CP0ToReg(CP0ToReg), .ExtrWord(ExtrWord), .CP0_out(CP0_out),
    .dmem(dmem), .mem_stall(mem_stall), .wb_PC(wb_PC), .wb_IR(wb_IR),
    .wb_RegWrite(wb_RegWrite), .wb_write(wb_write), .wb_data(wb_data), .wb_Syscall(wb_Syscall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    PC_in = 32'h0; IR_in = 32'h0; result_1 = 32'h0; regfile_out2 = 32'h0; CP0_out = 32'h0;
    write = 6'd0; MemToReg = 0; MemWrite = 0; RegWrite = 0; Jal = 0; Sh = 0; Sb = 0;
    ExtrSigned = 0; Syscall = 0; CP0ToReg = 0; ExtrWord = 2'b00;
  endtask

  // Inputs are already applied in IDLE; ack arrives on the nbusy-th BUSY cycle.
  task automatic run_mem(input string tag, input int nbusy, input logic [31:0] rd,
                         input logic [31:0] exp_addr, input logic exp_we,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    chk({tag, "_idle_stall"}, 32'(mem_stall), 32'd1);
    chk({tag, "_idle_req"},   32'(dmem.req),  32'd0);
    for (int i = 0; i < nbusy; i++) begin
      tick();
      chk({tag, "_busy_stall"}, 32'(mem_stall), 32'd1);
      chk({tag, "_busy_req"},   32'(dmem.req),  32'd1);
      chk({tag, "_addr"},       dmem.addr,      exp_addr);
      chk({tag, "_we"},         32'(dmem.we),   32'(exp_we));
      chk({tag, "_be"},         32'(dmem.be),   32'(exp_be));
      chk({tag, "_wdata"},      dmem.wdata,     exp_wdata);
      chk({tag, "_bubble_rw"},  32'(wb_RegWrite), 32'd0);
      chk({tag, "_bubble_pc"},  wb_PC,          32'd0);
      if (i == nbusy - 1) begin
        dmem.ack = 1'b1; dmem.rdata = rd;
      end
    end
    tick();
    dmem.ack = 1'b0; dmem.rdata = 32'h0;
    chk({tag, "_done_stall"}, 32'(mem_stall), 32'd0);
    chk({tag, "_done_req"},   32'(dmem.req),  32'd0);
    tick();
  endtask

  initial begin
    nop();
    dmem.ack = 1'b0; dmem.rdata = 32'h0;
    rst = 1'b1;
    #2;
    chk("rst_req",   32'(dmem.req),    32'd0);
    chk("rst_wb_rw", 32'(wb_RegWrite), 32'd0);
    chk("rst_wb_d",  wb_data,          32'd0);
    chk("rst_wb_pc", wb_PC,            32'd0);
    tick();
    rst = 1'b0;

    // ALU op passes straight through with no stall
    result_1 = 32'h1234; RegWrite = 1; write = 6'd5; PC_in = 32'h400; IR_in = 32'h11; Syscall = 1;
    #1 chk("alu_stall", 32'(mem_stall), 32'd0);
    tick();
    chk("alu_data", wb_data, 32'h1234);
    chk("alu_wr",   32'(wb_write), 32'd5);
    chk("alu_rw",   32'(wb_RegWrite), 32'd1);
    chk("alu_pc",   wb_PC, 32'h400);
    chk("alu_ir",   wb_IR, 32'h11);
    chk("alu_sys",  32'(wb_Syscall), 32'd1);
    chk("alu_stall2", 32'(mem_stall), 32'd0);

    // lb signed at offset 3, ack on first BUSY cycle
    nop();
    result_1 = 32'h103; MemToReg = 1; ExtrWord = 2'b10; ExtrSigned = 1; RegWrite = 1;
    write = 6'd7; PC_in = 32'h404;
    #1 run_mem("lb", 1, 32'h80FF0011, 32'h100, 1'b0, 4'hF, 32'h0);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    chk("lb_wr",   32'(wb_write), 32'd7);
    chk("lb_pc",   wb_PC, 32'h404);

    // lhu at offset 2, ack on 4th BUSY cycle
    nop();
    result_1 = 32'h102; MemToReg = 1; ExtrWord = 2'b01; RegWrite = 1; write = 6'd8;
    #1 run_mem("lhu", 4, 32'h8001FFFF, 32'h100, 1'b0, 4'hF, 32'h0);
    chk("lhu_data", wb_data, 32'h00008001);

    // sb at offset 1
    nop();
    result_1 = 32'h201; MemWrite = 1; Sb = 1; regfile_out2 = 32'hAABBCCDD; PC_in = 32'h408;
    #1 run_mem("sb", 2, 32'h0, 32'h200, 1'b1, 4'b0010, 32'hDDDDDDDD);
    chk("sb_pc", wb_PC, 32'h408);
    chk("sb_rw", 32'(wb_RegWrite), 32'd0);

    // sh at upper halfword
    nop();
    result_1 = 32'h202; MemWrite = 1; Sh = 1; regfile_out2 = 32'hAABBCCDD;
    #1 run_mem("sh", 1, 32'h0, 32'h200, 1'b1, 4'b1100, 32'hCCDDCCDD);

    // Sb outranks Sh
    nop();
    result_1 = 32'h203; MemWrite = 1; Sb = 1; Sh = 1; regfile_out2 = 32'h11223344;
    #1 run_mem("sbsh", 1, 32'h0, 32'h200, 1'b1, 4'b1000, 32'h44444444);

    // Jal, then CP0ToReg overriding Jal
    nop();
    PC_in = 32'hBFC00010; Jal = 1; RegWrite = 1; write = 6'd31; result_1 = 32'h55;
    tick();
    chk("jal_data", wb_data, 32'hBFC00014);
    CP0ToReg = 1; CP0_out = 32'hDEADBEEF;
    tick();
    chk("cp0_data", wb_data, 32'hDEADBEEF);

    // stray ack in IDLE is ignored
    nop();
    result_1 = 32'h77; dmem.ack = 1'b1; dmem.rdata = 32'hCAFEF00D;
    tick();
    chk("stray_stall", 32'(mem_stall), 32'd0);
    chk("stray_req",   32'(dmem.req),  32'd0);
    chk("stray_data",  wb_data,        32'h77);
    dmem.ack = 1'b0; dmem.rdata = 32'h0;

    // reset in the middle of an access, then the same load completes normally
    nop();
    result_1 = 32'h300; MemToReg = 1; ExtrWord = 2'b11; RegWrite = 1; write = 6'd9;
    tick();
    chk("mid_req", 32'(dmem.req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(dmem.req), 32'd0);
    chk("mid_rst_wd",  wb_data,       32'd0);
    chk("mid_rst_rw",  32'(wb_RegWrite), 32'd0);
    tick();
    rst = 1'b0;
    #1 run_mem("post_rst", 2, 32'h12345678, 32'h300, 1'b0, 4'hF, 32'h0);
    chk("post_rst_data", wb_data, 32'h12345678);
    chk("post_rst_wr",   32'(wb_write), 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
